// File: rtl/sram_arbiter.sv
// Round-robin front end that funnels CHANNELS req/ack masters onto one single-port
// synchronous SRAM. Every access takes four cycles (IDLE, ISSUE, RESP, ACK), and a write also returns the old word.
module sram_arbiter #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          ch_req,
  input  logic [CHANNELS-1:0]          ch_we,
  input  logic [CHANNELS*ADDR_W-1:0]   ch_address,
  input  logic [CHANNELS*DATA_W-1:0]   ch_wdata,
  output logic [CHANNELS-1:0]          ch_ack,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            data_out,
  output logic                         write_ena,
  input  logic [DATA_W-1:0]            data_in
);

  localparam int IDX_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ACK} state_t;

  state_t                            state, state_d;
  logic [IDX_W-1:0]                  grant, grant_d, last, last_d;
  logic [ADDR_W-1:0]                 address_d;
  logic [DATA_W-1:0]                 data_out_d, ch_rdata_d;
  logic                              write_ena_d;
  logic [CHANNELS-1:0]               ch_ack_d;
  logic [CHANNELS-1:0][ADDR_W-1:0]   addr_a;
  logic [CHANNELS-1:0][DATA_W-1:0]   wdata_a;
  logic                              pick_vld;
  logic [IDX_W-1:0]                  pick;

  assign addr_a  = ch_address;
  assign wdata_a = ch_wdata;

  // Lowest requester above 'last' wins; if there is none, wrap to the lowest requester overall.
  always_comb begin
    pick_vld = |ch_req;
    pick     = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (ch_req[i]) pick = IDX_W'(i);
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (ch_req[i] && i > int'(last)) pick = IDX_W'(i);
  end

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    last_d      = last;
    address_d   = address;
    data_out_d  = data_out;
    write_ena_d = write_ena;
    ch_ack_d    = ch_ack;
    ch_rdata_d  = ch_rdata;
    case (state)
      IDLE: begin
        write_ena_d = 1'b0;
        if (pick_vld) begin
          grant_d     = pick;
          last_d      = pick;
          address_d   = addr_a[pick];
          data_out_d  = wdata_a[pick];
          write_ena_d = ch_we[pick];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        write_ena_d = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        ch_rdata_d        = data_in;
        ch_ack_d          = '0;
        ch_ack_d[grant]   = 1'b1;
        state_d           = ACK;
      end
      ACK: begin
        ch_ack_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= IDX_W'(CHANNELS - 1);
      address   <= '0;
      data_out  <= '0;
      write_ena <= 1'b0;
      ch_ack    <= '0;
      ch_rdata  <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      last      <= last_d;
      address   <= address_d;
      data_out  <= data_out_d;
      write_ena <= write_ena_d;
      ch_ack    <= ch_ack_d;
      ch_rdata  <= ch_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a behavioural SRAM, directed vectors, reset corner cases and
// random multi-master traffic, all checked against a transaction-level round-robin model.
module tb_sram_arbiter;
  localparam int CH = 4;
  localparam int AW = 20;
  localparam int DW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [CH-1:0]     ch_req, ch_we, ch_ack;
  logic [CH*AW-1:0]  ch_address;
  logic [CH*DW-1:0]  ch_wdata;
  logic [DW-1:0]     ch_rdata, data_out, data_in;
  logic [AW-1:0]     address;
  logic              write_ena;

  sram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .ch_req(ch_req), .ch_we(ch_we),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_ack(ch_ack),
    .ch_rdata(ch_rdata), .address(address), .data_out(data_out),
    .write_ena(write_ena), .data_in(data_in)
  );

  always #5 clock = ~clock;

  // Registered-read SRAM; the preload port lets the bench seed contents while the DUT is idle.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clock) begin
    data_in <= mem[address];
    if (write_ena) mem[address] <= data_out;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  int checks = 0;
  int errors = 0;
  int model_last;

  typedef struct {
    int            ch;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic req, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_req[c]             = req;
    ch_we[c]              = we;
    ch_address[c*AW +: AW] = a;
    ch_wdata[c*DW +: DW]   = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clock);
    pre_en     = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic int rr_pick(input logic [CH-1:0] pend);
    for (int k = 1; k <= CH; k++)
      if (pend[(model_last + k) % CH]) return (model_last + k) % CH;
    return -1;
  endfunction

  // Bounded wait for the next ack; ch=-1 on timeout, -2 if the ack is not one-hot.
  task automatic wait_ack(output int c, output int cyc);
    c   = -1;
    cyc = 99;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      if (ch_ack != '0) begin
        cyc = n;
        for (int i = 0; i < CH; i++) if (ch_ack[i]) c = i;
        if (!$onehot(ch_ack)) c = -2;
        break;
      end
    end
  endtask

  task automatic do_access(input vec_t v, input string name);
    int c, cyc;
    @(negedge clock);
    set_ch(v.ch, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clock);
    check({name, " bus address"}, address, v.addr);
    check({name, " write strobe"}, write_ena, v.we);
    if (v.we) check({name, " bus data"}, data_out, v.wdata);
    wait_ack(c, cyc);
    check({name, " ack channel"}, c, v.ch);
    check({name, " ack latency"}, cyc, 2);
    check({name, " rdata"}, ch_rdata, v.exp);
    set_ch(v.ch, 1'b0, 1'b0, v.addr, v.wdata);
    if (v.we) ref_mem[v.addr] = v.wdata;
    model_last = v.ch;
  endtask

  initial begin
    int c, cyc, prev, acks, e;
    logic [CH-1:0]     pend;
    logic [CH-1:0]     p_we;
    logic [AW-1:0]     p_addr  [CH];
    logic [DW-1:0]     p_wdata [CH];
    vec_t v;

    reset = 1'b1; ch_req = '0; ch_we = '0; ch_address = '0; ch_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    for (int a = 0; a < 64; a++) preload(AW'(a), DW'($urandom));
    preload(20'h00000, 8'h77);
    preload(20'h00005, 8'h5A);
    preload(20'h00010, 8'h3C);
    preload(20'h00100, 8'h11);
    preload(20'h12345, 8'h9E);
    preload(20'hFFFFF, 8'h00);

    // Reset with every channel requesting: bus idle, channel 0 wins after release.
    @(negedge clock);
    for (int i = 0; i < CH; i++) set_ch(i, 1'b1, 1'b0, AW'(5 + 16 * i), 8'h00);
    @(negedge clock);
    check("reset ch_ack", ch_ack, 0);
    check("reset ch_rdata", ch_rdata, 0);
    check("reset address", address, 0);
    check("reset data_out", data_out, 0);
    check("reset write_ena", write_ena, 0);
    reset = 1'b0;
    model_last = CH - 1;
    @(negedge clock);
    check("first grant address", address, 20'h00005);
    for (int i = 0; i < CH; i++) ch_req[i] = 1'b0;
    wait_ack(c, cyc);
    check("first grant channel", c, 0);
    check("first grant latency", cyc, 2);
    check("first grant rdata", ch_rdata, 8'h5A);
    model_last = 0;

    tbl[0] = '{1, 1'b1, 20'h12345, 8'hA5, 8'h9E};
    tbl[1] = '{1, 1'b0, 20'h12345, 8'h00, 8'hA5};
    tbl[2] = '{2, 1'b1, 20'h00010, 8'hC3, 8'h3C};
    tbl[3] = '{2, 1'b0, 20'h00010, 8'h00, 8'hC3};
    tbl[4] = '{3, 1'b1, 20'hFFFFF, 8'hFF, 8'h00};
    tbl[5] = '{3, 1'b0, 20'hFFFFF, 8'h00, 8'hFF};
    tbl[6] = '{0, 1'b0, 20'h00000, 8'h00, 8'h77};
    tbl[7] = '{3, 1'b1, 20'hFFFFF, 8'h00, 8'hFF};
    for (int k = 0; k < 8; k++) do_access(tbl[k], $sformatf("vec%0d", k));

    // Reset lands while a write is on the bus: strobe drops at once, no ack, memory untouched.
    @(negedge clock);
    set_ch(0, 1'b1, 1'b1, 20'h00100, 8'h55);
    @(negedge clock);
    check("abort strobe before reset", write_ena, 1);
    #1 reset = 1'b1;
    #1;
    check("abort strobe after reset", write_ena, 0);
    check("abort address after reset", address, 0);
    set_ch(0, 1'b0, 1'b0, 20'h00100, 8'h55);
    @(negedge clock);
    reset = 1'b0;
    model_last = CH - 1;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (ch_ack != '0) acks++;
    end
    check("abort ack count", acks, 0);
    v = '{0, 1'b0, 20'h00100, 8'h00, 8'h11};
    do_access(v, "abort readback");

    // Fairness: all channels request continuously from a fresh reset.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_last = CH - 1;
    for (int i = 0; i < CH; i++) set_ch(i, 1'b1, 1'b0, AW'(32 + i), 8'h00);
    prev = -1;
    for (int k = 0; k < 16; k++) begin
      wait_ack(c, cyc);
      check($sformatf("fair%0d channel", k), c, k % CH);
      check($sformatf("fair%0d spacing", k), cyc, (k == 0) ? 3 : 4);
      if (c >= 0) check($sformatf("fair%0d rdata", k), ch_rdata, ref_mem[AW'(32 + c)]);
      if (c == prev) check($sformatf("fair%0d repeat", k), c, prev + 1);
      prev = c;
    end
    for (int i = 0; i < CH; i++) ch_req[i] = 1'b0;
    model_last = CH - 1;

    // Random traffic: requests held until acked, new ones raised in the ack cycle.
    pend = '0;
    p_we = '0;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < CH; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i]    = 1'b1;
          p_we[i]    = 1'($urandom_range(1, 0));
          p_addr[i]  = AW'($urandom_range(63, 0));
          p_wdata[i] = DW'($urandom);
          set_ch(i, 1'b1, p_we[i], p_addr[i], p_wdata[i]);
        end
      end
      if (pend == '0) begin
        c          = $urandom_range(CH - 1, 0);
        pend[c]    = 1'b1;
        p_we[c]    = 1'b1;
        p_addr[c]  = AW'($urandom_range(63, 0));
        p_wdata[c] = DW'($urandom);
        set_ch(c, 1'b1, p_we[c], p_addr[c], p_wdata[c]);
      end
      e = rr_pick(pend);
      wait_ack(c, cyc);
      check($sformatf("rand%0d channel", t), c, e);
      check($sformatf("rand%0d spacing", t), cyc, 4);
      check($sformatf("rand%0d rdata", t), ch_rdata, ref_mem[p_addr[e]]);
      if (p_we[e]) ref_mem[p_addr[e]] = p_wdata[e];
      model_last = e;
      pend[e]    = 1'b0;
      ch_req[e]  = 1'b0;
    end
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
